// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-outstanding 64-bit word RAM responder with programmable latency
//
// Purpose: memory-side responder for the core's fetch/load/store port. Holds a 2**ADDR_W x 64-bit
// RAM and answers one request at a time. The access itself happens at the accept edge; the result
// is held internally and presented LATENCY cycles later.
//
// Parameters:
//   ADDR_W   word-index width (RAM depth 2**ADDR_W words, byte span 2**(ADDR_W+3))
//   LATENCY  cycles from accept edge to resp_valid, 1..15
//
// Ports:
//   clk         clock, all state on posedge
//   rst         asynchronous reset, active-low
//   req_valid   request present              req_ready   responder idle and out of reset
//   req_addr    64-bit byte address          req_we      1 = write, 0 = read
//   req_wdata   write data                   req_wstrb   byte enables, bit i -> bits [8i+7:8i]
//   resp_valid  response present             resp_ready  initiator takes response
//   resp_rdata  read data (0 for writes, errors and while no response is shown)
//   resp_err    misaligned or out-of-range request
//
// Optional feature (macro MEM_RESPONDER_STATS_EN): adds 32-bit wrapping counters rd_cnt, wr_cnt,
// err_cnt for accepted non-error reads, non-error writes and errors.

module mem_responder #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic        req_we,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
`ifdef MEM_RESPONDER_STATS_EN
  ,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt,
  output logic [31:0] err_cnt
`endif
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("mem_responder: LATENCY must be within 1..15");
  end

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic [63:0]         r_rdata;
  logic                r_err;
  logic [63:0]         r_mem [0:(2**ADDR_W)-1];

  logic                w_accept;
  logic                w_err;
  logic [ADDR_W-1:0]   w_idx;

  assign w_accept = req_valid & req_ready;
  assign w_idx    = req_addr[ADDR_W+2:3];
  // Anything above the RAM's byte span, or not word aligned, is rejected.
  assign w_err    = (req_addr[2:0] != 3'd0) | (req_addr[63:ADDR_W+3] != '0);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = (LATENCY > 1) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs; result registers stay hidden until the response phase.
  always_comb begin
    req_ready  = rst & (r_state == S_IDLE);
    resp_valid = (r_state == S_RESP);
    resp_rdata = resp_valid ? r_rdata : 64'd0;
    resp_err   = resp_valid & r_err;
  end

  // Latency counter and latched result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= 4'd0;
      r_rdata <= 64'd0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= LAT_M1;
      r_err   <= w_err;
      r_rdata <= (w_err || req_we) ? 64'd0 : r_mem[w_idx];
    end else if (r_state == S_WAIT) begin
      r_cnt   <= r_cnt - 4'd1;
    end
  end

  // RAM has no reset so its contents survive a reset of the control logic.
  always_ff @(posedge clk) begin
    if (w_accept && req_we && !w_err) begin
      for (int b = 0; b < 8; b++) begin
        if (req_wstrb[b]) begin
          r_mem[w_idx][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
    end
  end

`ifdef MEM_RESPONDER_STATS_EN
  logic [31:0] r_rd_cnt;
  logic [31:0] r_wr_cnt;
  logic [31:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_cnt  <= 32'd0;
      r_wr_cnt  <= 32'd0;
      r_err_cnt <= 32'd0;
    end else if (w_accept) begin
      if (w_err) begin
        r_err_cnt <= r_err_cnt + 32'd1;
      end else if (req_we) begin
        r_wr_cnt  <= r_wr_cnt + 32'd1;
      end else begin
        r_rd_cnt  <= r_rd_cnt + 32'd1;
      end
    end
  end

  assign rd_cnt  = r_rd_cnt;
  assign wr_cnt  = r_wr_cnt;
  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized self-checking bench for mem_responder against a behavioural model

module tb_mem_responder;

  localparam int AW  = 12;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_addr = 64'd0;
  logic        req_we = 1'b0;
  logic [63:0] req_wdata = 64'd0;
  logic [7:0]  req_wstrb = 8'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic        resp_err;
`ifdef MEM_RESPONDER_STATS_EN
  logic [31:0] rd_cnt, wr_cnt, err_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  mem_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_we     (req_we),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
`ifdef MEM_RESPONDER_STATS_EN
    ,
    .rd_cnt     (rd_cnt),
    .wr_cnt     (wr_cnt),
    .err_cnt    (err_cnt)
`endif
  );

  // Two extra instances at the latency extremes for back-to-back spacing.
  logic        a_rst = 1'b0;
  logic        a_we = 1'b0;
  logic [63:0] a_wdata = 64'h5A5A_0F0F_1234_ABCD;
  logic        a_req_valid [2];
  logic        a_req_ready [2];
  logic        a_resp_valid [2];
  logic [63:0] a_rdata [2];
  logic        a_err [2];
`ifdef MEM_RESPONDER_STATS_EN
  logic [31:0] a_rd [2];
  logic [31:0] a_wr [2];
  logic [31:0] a_ec [2];
`endif

  initial begin
    a_req_valid[0] = 1'b0;
    a_req_valid[1] = 1'b0;
  end

  for (genvar j = 0; j < 2; j++) begin : g_aux
    mem_responder #(.ADDR_W(AW), .LATENCY((j == 0) ? 1 : 15)) u_aux (
      .clk        (clk),
      .rst        (a_rst),
      .req_valid  (a_req_valid[j]),
      .req_ready  (a_req_ready[j]),
      .req_addr   (64'h40),
      .req_we     (a_we),
      .req_wdata  (a_wdata),
      .req_wstrb  (8'hFF),
      .resp_valid (a_resp_valid[j]),
      .resp_ready (1'b1),
      .resp_rdata (a_rdata[j]),
      .resp_err   (a_err[j])
`ifdef MEM_RESPONDER_STATS_EN
      ,
      .rd_cnt     (a_rd[j]),
      .wr_cnt     (a_wr[j]),
      .err_cnt    (a_ec[j])
`endif
    );
  end

  // ---------------- behavioural model ----------------
  logic [63:0] mmem   [int];
  logic [7:0]  mknown [int];
  bit          m_busy = 1'b0;
  int          m_left = 0;
  logic [63:0] m_rdata = 64'd0;
  logic [63:0] m_rmask = 64'd0;
  bit          m_err = 1'b0;
  logic [31:0] m_rd = 32'd0, m_wr = 32'd0, m_ec = 32'd0;

  task automatic model_accept();
    int          idx;
    bit          err;
    idx = int'(req_addr[AW+2:3]);
    err = (req_addr[2:0] != 3'd0) || ((req_addr >> (AW + 3)) != 64'd0);
    m_busy  = 1'b1;
    m_left  = LAT - 1;
    m_err   = err;
    m_rdata = 64'd0;
    m_rmask = '1;
    if (err) begin
      m_ec++;
    end else if (req_we) begin
      m_wr++;
      if (!mmem.exists(idx)) begin
        mmem[idx]   = 64'd0;
        mknown[idx] = 8'd0;
      end
      for (int b = 0; b < 8; b++) begin
        if (req_wstrb[b]) begin
          mmem[idx][8*b +: 8] = req_wdata[8*b +: 8];
          mknown[idx][b]      = 1'b1;
        end
      end
    end else begin
      m_rd++;
      if (mmem.exists(idx)) begin
        m_rdata = mmem[idx];
        for (int b = 0; b < 8; b++) m_rmask[8*b +: 8] = {8{mknown[idx][b]}};
      end else begin
        m_rmask = 64'd0;
      end
    end
  endtask

  // Compare on every falling edge, then advance the model across the coming rising edge.
  always @(negedge clk) begin
    bit exp_valid;
    if (!rst) begin
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_resp_rdata", resp_rdata, 64'd0);
      chk("rst_resp_err", 64'(resp_err), 64'd0);
      m_busy = 1'b0;
      m_rd = 32'd0; m_wr = 32'd0; m_ec = 32'd0;
    end else begin
      exp_valid = m_busy && (m_left == 0);
      chk("req_ready", 64'(req_ready), 64'(!m_busy));
      chk("resp_valid", 64'(resp_valid), 64'(exp_valid));
      if (exp_valid) begin
        chk("resp_rdata", resp_rdata & m_rmask, m_rdata & m_rmask);
        chk("resp_err", 64'(resp_err), 64'(m_err));
      end else begin
        chk("idle_rdata", resp_rdata, 64'd0);
        chk("idle_err", 64'(resp_err), 64'd0);
      end
`ifdef MEM_RESPONDER_STATS_EN
      chk("rd_cnt", 64'(rd_cnt), 64'(m_rd));
      chk("wr_cnt", 64'(wr_cnt), 64'(m_wr));
      chk("err_cnt", 64'(err_cnt), 64'(m_ec));
`endif
      if (!m_busy) begin
        if (req_valid) model_accept();
      end else if (m_left > 0) begin
        m_left--;
      end else if (resp_ready) begin
        m_busy = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_accept();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("accept_timeout", 64'(n), 64'd0);
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (resp_valid) break;
    end
    if (!resp_valid) chk("resp_timeout", 64'(lat), 64'(LAT));
  endtask

  task automatic do_req(input bit we, input logic [63:0] addr, input logic [63:0] wd,
                        input logic [7:0] ws, input int hold,
                        output logic [63:0] rd, output logic er, output int lat);
    bit stable;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = ws;
    resp_ready = (hold == 0);
    wait_accept();
    @(posedge clk); #1;
    // Junk on the request lines while busy must be ignored.
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom}; req_wstrb = 8'($urandom);
    wait_resp(lat);
    rd = resp_rdata;
    er = resp_err;
    if (hold > 0) begin
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!(resp_valid && resp_rdata === rd && resp_err === er && !req_ready)) stable = 1'b0;
      end
      chk("bp_stable", 64'(stable), 64'd1);
      @(posedge clk); #1;
      resp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_release_req_ready", 64'(req_ready), 64'd1);
      chk("bp_release_resp_valid", 64'(resp_valid), 64'd0);
    end
  endtask

  task automatic run_b2b(input int j, input int lat);
    int acc = 0, nresp = 0, cyc = 0, t_prev = -1;
    @(posedge clk); #1;
    a_we = 1'b1;
    a_req_valid[j] = 1'b1;
    while (nresp < 5 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (a_resp_valid[j]) begin
        chk($sformatf("b2b_err_L%0d", lat), 64'(a_err[j]), 64'd0);
        chk($sformatf("b2b_rdata_L%0d", lat), a_rdata[j], (nresp == 0) ? 64'd0 : a_wdata);
        if (t_prev >= 0) chk($sformatf("b2b_spacing_L%0d", lat), 64'(cyc - t_prev), 64'(lat + 1));
        t_prev = cyc;
        nresp++;
      end
      if (a_req_valid[j] && a_req_ready[j]) acc++;
      @(posedge clk); #1;
      if (acc >= 1) a_we = 1'b0;
      if (acc >= 5) a_req_valid[j] = 1'b0;
    end
    chk($sformatf("b2b_count_L%0d", lat), 64'(nresp), 64'd5);
`ifdef MEM_RESPONDER_STATS_EN
    chk($sformatf("b2b_rd_cnt_L%0d", lat), 64'(a_rd[j]), 64'd4);
    chk($sformatf("b2b_wr_cnt_L%0d", lat), 64'(a_wr[j]), 64'd1);
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] rd;
    logic        er;
    int          lat;
    int          cnt;
    logic [63:0] addr;

    repeat (3) @(negedge clk);
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    chk("reset_resp_valid", 64'(resp_valid), 64'd0);
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    chk("release_req_ready", 64'(req_ready), 64'd1);

    // Full write then read
    do_req(1'b1, 64'h10, 64'h1122334455667788, 8'hFF, 0, rd, er, lat);
    chk("t1_wr_latency", 64'(lat), 64'd2);
    chk("t1_wr_err", 64'(er), 64'd0);
    chk("t1_wr_rdata", rd, 64'd0);
    do_req(1'b0, 64'h10, 64'd0, 8'd0, 0, rd, er, lat);
    chk("t1_rd_rdata", rd, 64'h1122334455667788);
    chk("t1_rd_latency", 64'(lat), 64'd2);

    // Partial write
    do_req(1'b1, 64'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 0, rd, er, lat);
    do_req(1'b0, 64'h10, 64'd0, 8'd0, 0, rd, er, lat);
    chk("t2_partial", rd, 64'h11223344AAAAAAAA);

    // Errors
    do_req(1'b1, 64'h0, 64'hCAFEF00DDEADBEEF, 8'hFF, 0, rd, er, lat);
    do_req(1'b0, 64'h13, 64'd0, 8'd0, 0, rd, er, lat);
    chk("t3_misaligned_err", 64'(er), 64'd1);
    chk("t3_misaligned_rdata", rd, 64'd0);
    do_req(1'b1, 64'h8000, 64'h0, 8'hFF, 0, rd, er, lat);
    chk("t3_range_err", 64'(er), 64'd1);
    do_req(1'b0, 64'h0, 64'd0, 8'd0, 0, rd, er, lat);
    chk("t3_ram_unchanged", rd, 64'hCAFEF00DDEADBEEF);
`ifdef MEM_RESPONDER_STATS_EN
    @(negedge clk);
    chk("t3_err_cnt", 64'(err_cnt), 64'd2);
    chk("t3_rd_cnt", 64'(rd_cnt), 64'd3);
    chk("t3_wr_cnt", 64'(wr_cnt), 64'd3);
`endif

    // Backpressure
    do_req(1'b0, 64'h10, 64'd0, 8'd0, 10, rd, er, lat);
    chk("t4_bp_rdata", rd, 64'h11223344AAAAAAAA);

    // Reset during WAIT after a write
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h28;
    req_wdata = 64'h0123456789ABCDEF; req_wstrb = 8'hFF; resp_ready = 1'b1;
    wait_accept();
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("t5_wait_rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("t5_wait_rst_req_ready", 64'(req_ready), 64'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (resp_valid) cnt++;
    end
    chk("t5_no_resp_after_reset", 64'(cnt), 64'd0);
    do_req(1'b0, 64'h28, 64'd0, 8'd0, 0, rd, er, lat);
    chk("t5_write_committed", rd, 64'h0123456789ABCDEF);

    // Reset while a response is being shown
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h10; resp_ready = 1'b0;
    wait_accept();
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_resp(lat);
    #2 rst = 1'b0;
    #1;
    chk("t5_resp_rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("t5_resp_rst_rdata", resp_rdata, 64'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    resp_ready = 1'b1;

    // Randomized traffic
    for (int t = 0; t < 250; t++) begin
      addr = 64'($urandom_range(0, 15)) << 3;
      case ($urandom_range(0, 9))
        0: addr = addr | 64'($urandom_range(1, 7));
        1: addr = addr | (64'd1 << $urandom_range(AW + 3, 63));
        default: ;
      endcase
      do_req(1'($urandom), addr, {$urandom, $urandom}, 8'($urandom),
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, rd, er, lat);
      chk("rand_latency", 64'(lat), 64'(LAT));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (4) @(negedge clk);

    // Back-to-back at the latency extremes
    @(posedge clk); #2;
    a_rst = 1'b1;
    run_b2b(0, 1);
    run_b2b(1, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
